fp_acc3_ctrl: RTL



---
 rtl/fp_acc3_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_acc3_ctrl.sv
// -----------------------------------------------------------------------------
// fp_acc3_ctrl
//
// Accumulation sequencer for a 3-operand floating-point adder. It reduces an
// arbitrary-length FP element stream (for example FC-layer dot-product partials)
// to one sum per vector. Each step issues {running partial, x[2k], x[2k+1]} to
// the adder. The adder result is then captured as the new partial. An odd tail
// element is padded with +0. No arithmetic or rounding happens in this block.
//
// Optional feature: define FP_ACC3_BIAS_EN to add the bias_i port. The partial
// of each vector then starts at bias_i, sampled with the vector's first
// accepted element, instead of +0.
//
// Parameters:
//   EXPONENT     exponent width
//   MANTISSA     stored mantissa width
//   ADD_LATENCY  cycles from the issue cycle (sync_o=1) to a valid adder_i, 1..7
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   data_i/valid_i/last_i input element stream; last_i marks the final element
//   ready_o               element accepted when valid_i && ready_o
//   a1_o/a2_o/a3_o        registered adder operands (held after the issue)
//   sync_o                registered adder enable, high for one cycle per step
//   adder_i               adder result
//   bias_i                per-vector initial partial (FP_ACC3_BIAS_EN only)
//   sum_o                 final vector sum, held until the next result
//   sum_valid_o           one-cycle pulse when sum_o updates
//   busy_o                buffer holds an element or a step is in flight
// -----------------------------------------------------------------------------
module fp_acc3_ctrl #(
   parameter  int EXPONENT    = 8,
   parameter  int MANTISSA    = 23,
   parameter  int ADD_LATENCY = 1,
   localparam int W           = EXPONENT + MANTISSA + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] data_i,
   input  logic         valid_i,
   input  logic         last_i,
   output logic         ready_o,
   output logic [W-1:0] a1_o,
   output logic [W-1:0] a2_o,
   output logic [W-1:0] a3_o,
   output logic         sync_o,
   input  logic [W-1:0] adder_i,
`ifdef FP_ACC3_BIAS_EN
   input  logic [W-1:0] bias_i,
`endif
   output logic [W-1:0] sum_o,
   output logic         sum_valid_o,
   output logic         busy_o
);

   if (ADD_LATENCY < 1 || ADD_LATENCY > 7) begin : g_bad_latency
      $error("fp_acc3_ctrl: ADD_LATENCY must be in 1..7");
   end

   localparam logic [W-1:0] FP_ZERO   = '0;
   localparam logic [2:0]   WCNT_INIT = 3'(ADD_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2
   } state_t;

   state_t       state,     state_d;
   logic [2:0]   wcnt,      wcnt_d;
   logic [W-1:0] buf0,      buf0_d;
   logic         have0,     have0_d;
   logic         fin,       fin_d;
   logic [W-1:0] partial,   partial_d;
   logic [W-1:0] a1_d,      a2_d,      a3_d;
   logic         sync_d;
   logic [W-1:0] sum_d;
   logic         sum_valid_d;
   logic [W-1:0] part_base;

`ifdef FP_ACC3_BIAS_EN
   // vec_active marks that the current vector has taken its first element.
   // Until then, the partial is taken from bias_i rather than the register.
   logic vec_active, vec_active_d;
   assign part_base = vec_active ? partial : bias_i;
`else
   assign part_base = partial;
`endif

   assign ready_o = (state == ST_COLLECT);
   assign busy_o  = have0 || (state != ST_COLLECT);

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every next value defaults to its current register (or to an idle
      // value) before the case statement, so no path leaves a variable
      // unassigned and no latch is inferred.
      state_d     = state;
      wcnt_d      = wcnt;
      buf0_d      = buf0;
      have0_d     = have0;
      fin_d       = fin;
      partial_d   = partial;
      a1_d        = a1_o;
      a2_d        = a2_o;
      a3_d        = a3_o;
      sync_d      = 1'b0;
      sum_d       = sum_o;
      sum_valid_d = 1'b0;
`ifdef FP_ACC3_BIAS_EN
      vec_active_d = vec_active;
`endif

      case (state)
         ST_COLLECT: begin
            if (valid_i) begin
               if (!have0 && !last_i) begin
                  // The first element of a pair waits in the buffer.
                  buf0_d  = data_i;
                  have0_d = 1'b1;
`ifdef FP_ACC3_BIAS_EN
                  if (!vec_active) begin
                     partial_d    = bias_i;
                     vec_active_d = 1'b1;
                  end
`endif
               end else begin
                  // A pair is complete, or the vector ends here. Issue the
                  // step, padding a missing second operand with +0.
                  a1_d    = part_base;
                  a2_d    = have0 ? buf0   : data_i;
                  a3_d    = have0 ? data_i : FP_ZERO;
                  sync_d  = 1'b1;
                  fin_d   = last_i;
                  have0_d = 1'b0;
                  state_d = ST_ISSUE;
`ifdef FP_ACC3_BIAS_EN
                  vec_active_d = 1'b1;
`endif
               end
            end
         end

         ST_ISSUE: begin
            wcnt_d  = WCNT_INIT;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            if (wcnt == 3'd0) begin
               partial_d = adder_i;
               state_d   = ST_COLLECT;
               if (fin) begin
                  // The vector is complete. Publish the sum and restart from
                  // a clean partial, so the next vector inherits nothing.
                  sum_d       = adder_i;
                  sum_valid_d = 1'b1;
                  partial_d   = FP_ZERO;
                  have0_d     = 1'b0;
                  fin_d       = 1'b0;
`ifdef FP_ACC3_BIAS_EN
                  vec_active_d = 1'b0;
`endif
               end
            end else begin
               wcnt_d = wcnt - 3'd1;
            end
         end

         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_COLLECT;
         wcnt        <= 3'd0;
         buf0        <= '0;
         have0       <= 1'b0;
         fin         <= 1'b0;
         partial     <= '0;
         a1_o        <= '0;
         a2_o        <= '0;
         a3_o        <= '0;
         sync_o      <= 1'b0;
         sum_o       <= '0;
         sum_valid_o <= 1'b0;
`ifdef FP_ACC3_BIAS_EN
         vec_active  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments make every register update from
         // values that were stable before the edge, which is what the
         // hardware does.
         state       <= state_d;
         wcnt        <= wcnt_d;
         buf0        <= buf0_d;
         have0       <= have0_d;
         fin         <= fin_d;
         partial     <= partial_d;
         a1_o        <= a1_d;
         a2_o        <= a2_d;
         a3_o        <= a3_d;
         sync_o      <= sync_d;
         sum_o       <= sum_d;
         sum_valid_o <= sum_valid_d;
`ifdef FP_ACC3_BIAS_EN
         vec_active  <= vec_active_d;
`endif
      end
   end

endmodule
